// File: rtl/usr_cmd_sequencer.sv
// Command sequencer feeding a 6-bit universal shift register: FIFO-buffered commands replayed rpt+1 cycles.
// Define USRSEQ_DONE_CNT_EN to add the done_cnt completion counter output.
module usr_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RPT_W = 4
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [5:0]             cmd_data,
  input  logic                   cmd_rsi,
  input  logic                   cmd_lsi,
  input  logic [RPT_W-1:0]       cmd_rpt,
  output logic [2:0]             A,
  output logic [5:0]             D,
  output logic                   RSI,
  output logic                   LSI,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
`ifdef USRSEQ_DONE_CNT_EN
  ,
  output logic [7:0]             done_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [5:0]       data;
    logic             rsi;
    logic             lsi;
    logic [RPT_W-1:0] rpt;
  } cmd_t;

  state_t           state_q, state_d;
  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  cmd_t             cmd_in;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [2:0]       a_q, a_d;
  logic [5:0]       d_q, d_d;
  logic             rsi_q, rsi_d;
  logic             lsi_q, lsi_d;
  logic             busy_q, busy_d;
  logic             push;
  logic             pop;
`ifdef USRSEQ_DONE_CNT_EN
  logic [7:0]       done_cnt_q, done_cnt_d;
`endif

  assign cmd_in    = {cmd_op, cmd_data, cmd_rsi, cmd_lsi, cmd_rpt};
  assign head      = mem_q[rd_ptr_q];
  assign cmd_ready = (level_q < LVL_W'(DEPTH));

  // Next-state: replay control, FIFO pointers/occupancy, output registers.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rpt_cnt_d = rpt_cnt_q;
    a_d       = a_q;
    d_d       = d_q;
    rsi_d     = rsi_q;
    lsi_d     = lsi_q;
    busy_d    = busy_q;
    pop       = 1'b0;
    push      = cmd_valid && cmd_ready && !flush;
`ifdef USRSEQ_DONE_CNT_EN
    done_cnt_d = done_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) pop = 1'b1;
      end
      S_ISSUE: begin
        if (rpt_cnt_q != '0) begin
          rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
        end else begin
`ifdef USRSEQ_DONE_CNT_EN
          done_cnt_d = done_cnt_q + 8'd1;
`endif
          if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            a_d     = 3'b000;
            d_d     = 6'b000000;
            rsi_d   = 1'b0;
            lsi_d   = 1'b0;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pop reads the registered head, so a same-cycle push never bypasses the FIFO.
    if (pop) begin
      state_d   = S_ISSUE;
      busy_d    = 1'b1;
      a_d       = head.op;
      d_d       = head.data;
      rsi_d     = head.rsi;
      lsi_d     = head.lsi;
      rpt_cnt_d = head.rpt;
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    level_d = level_q + LVL_W'(push) - LVL_W'(pop);

    if (flush) begin
      state_d   = S_IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      rpt_cnt_d = '0;
      a_d       = 3'b000;
      d_d       = 6'b000000;
      rsi_d     = 1'b0;
      lsi_d     = 1'b0;
      busy_d    = 1'b0;
`ifdef USRSEQ_DONE_CNT_EN
      done_cnt_d = 8'd0;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rpt_cnt_q <= '0;
      a_q       <= 3'b000;
      d_q       <= 6'b000000;
      rsi_q     <= 1'b0;
      lsi_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef USRSEQ_DONE_CNT_EN
      done_cnt_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rpt_cnt_q <= rpt_cnt_d;
      a_q       <= a_d;
      d_q       <= d_d;
      rsi_q     <= rsi_d;
      lsi_q     <= lsi_d;
      busy_q    <= busy_d;
`ifdef USRSEQ_DONE_CNT_EN
      done_cnt_q <= done_cnt_d;
`endif
    end
  end

  // Entry storage needs no reset: occupancy is tracked by level.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign A     = a_q;
  assign D     = d_q;
  assign RSI   = rsi_q;
  assign LSI   = lsi_q;
  assign busy  = busy_q;
  assign level = level_q;
`ifdef USRSEQ_DONE_CNT_EN
  assign done_cnt = done_cnt_q;
`endif

endmodule
